// File: rtl/pipe_mem_ext_if.sv
// EX -> MEM handshake and MEM/WB register bundle for pipe_mem_ext.
// master: the EX-side driver; slave: the MEM stage itself.
interface pipe_mem_ext_if;
  // EX stage inputs
  logic        in_valid;
  logic [31:0] alu_out;
  logic [31:0] pc4;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  rf_waddr;
  logic        rf_wena;
  logic [2:0]  rf_mux_sel;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  size;
  logic        sign_ext;

  // Stage outputs
  logic        stall;
  logic        misalign;
  logic        wb_valid;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_pc4;
  logic [31:0] wb_rs_data;
  logic [4:0]  wb_rf_waddr;
  logic        wb_rf_wena;
  logic [2:0]  wb_rf_mux_sel;

  modport master (
    output in_valid, alu_out, pc4, rs_data, rt_data, rf_waddr, rf_wena, rf_mux_sel,
           mem_rd, mem_wr, size, sign_ext,
    input  stall, misalign, wb_valid, wb_alu_out, wb_mem_data, wb_pc4, wb_rs_data,
           wb_rf_waddr, wb_rf_wena, wb_rf_mux_sel
  );

  modport slave (
    input  in_valid, alu_out, pc4, rs_data, rt_data, rf_waddr, rf_wena, rf_mux_sel,
           mem_rd, mem_wr, size, sign_ext,
    output stall, misalign, wb_valid, wb_alu_out, wb_mem_data, wb_pc4, wb_rs_data,
           wb_rf_waddr, wb_rf_wena, wb_rf_mux_sel
  );
endinterface

// File: rtl/pipe_mem_ext.sv
// MEM pipeline stage with byte-lane data memory, configurable access latency,
// misalignment suppression and a built-in MEM/WB register.
module pipe_mem_ext #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  pipe_mem_ext_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  localparam bit         HasWait  = (WAIT_CYCLES != 0);
  // Only meaningful when HasWait; the wrap for WAIT_CYCLES=0 is never loaded.
  localparam logic [2:0] WaitLoad = 3'(WAIT_CYCLES - 1);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [4:0]        waddr;
    logic              wena;
    logic [2:0]        mux;
    logic              rd;
    logic              wr;
    logic [1:0]        size;
    logic              sext;
  } op_t;

  logic [0:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  op_t               hold_q, hold_d;
  op_t               in_op, cur;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              is_mem, is_rd, is_wr, aligned, fire, mem_we;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata, rdata, ld_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  logic              wb_valid_q, wb_valid_d;
  logic              misalign_q, misalign_d;
  logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
  logic [DATA_W-1:0] wb_mem_q, wb_mem_d;
  logic [DATA_W-1:0] wb_pc4_q, wb_pc4_d;
  logic [DATA_W-1:0] wb_rs_q, wb_rs_d;
  logic [4:0]        wb_waddr_q, wb_waddr_d;
  logic              wb_wena_q, wb_wena_d;
  logic [2:0]        wb_mux_q, wb_mux_d;

  // Gather the live EX inputs; WAIT works from the held copy instead.
  always_comb begin
    in_op.alu   = bus.alu_out;
    in_op.pc4   = bus.pc4;
    in_op.rs    = bus.rs_data;
    in_op.rt    = bus.rt_data;
    in_op.waddr = bus.rf_waddr;
    in_op.wena  = bus.rf_wena;
    in_op.mux   = bus.rf_mux_sel;
    in_op.rd    = bus.mem_rd;
    in_op.wr    = bus.mem_wr;
    in_op.size  = bus.size;
    in_op.sext  = bus.sign_ext;
    cur         = (state_q == StWait) ? hold_q : in_op;
  end

  // Decode the active op: store wins over load, alignment by access size.
  always_comb begin
    is_wr    = cur.wr;
    is_rd    = cur.rd & ~cur.wr;
    is_mem   = cur.rd | cur.wr;
    word_idx = cur.alu[ADDR_W+1:2];
    lane     = cur.alu[1:0];
    case (cur.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~cur.alu[0];
      default: aligned = (cur.alu[1:0] == 2'b00);
    endcase
    // fire: the edge at which the access happens and WB is loaded
    fire = ((state_q == StIdle) && bus.in_valid && (!is_mem || !HasWait)) ||
           ((state_q == StWait) && (cnt_q == 3'd0));
    mem_we = fire && is_wr && aligned && !rst;
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    be    = 4'b0000;
    wdata = cur.rt;
    case (cur.size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{cur.rt[7:0]}};
      end
      2'b01: begin
        be    = cur.alu[1] ? 4'b1100 : 4'b0011;
        wdata = {2{cur.rt[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = cur.rt;
      end
    endcase
  end

  // Data memory: per-lane writes, never cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Load extraction: right-justify the selected lane(s) and extend.
  always_comb begin
    rdata   = mem_q[word_idx];
    ld_byte = rdata[{lane, 3'b000} +: 8];
    ld_half = cur.alu[1] ? rdata[31:16] : rdata[15:0];
    case (cur.size)
      2'b00:   ld_data = cur.sext ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
      2'b01:   ld_data = cur.sext ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

  // FSM next state: enter WAIT for memory ops when latency is configured.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid && is_mem && HasWait) begin
          state_d = StWait;
          cnt_d   = WaitLoad;
          hold_d  = in_op;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // MEM/WB next values; fields hold when nothing completes.
  always_comb begin
    wb_valid_d = fire;
    misalign_d = fire && is_mem && !aligned;
    wb_alu_d   = wb_alu_q;
    wb_mem_d   = wb_mem_q;
    wb_pc4_d   = wb_pc4_q;
    wb_rs_d    = wb_rs_q;
    wb_waddr_d = wb_waddr_q;
    wb_wena_d  = wb_wena_q;
    wb_mux_d   = wb_mux_q;
    if (fire) begin
      wb_alu_d   = cur.alu;
      wb_mem_d   = is_rd ? ld_data : cur.rt;
      wb_pc4_d   = cur.pc4;
      wb_rs_d    = cur.rs;
      wb_waddr_d = cur.waddr;
      wb_wena_d  = cur.wena && !(is_mem && !aligned);
      wb_mux_d   = cur.mux;
    end
  end

  // State and MEM/WB registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      hold_q     <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      wb_alu_q   <= '0;
      wb_mem_q   <= '0;
      wb_pc4_q   <= '0;
      wb_rs_q    <= '0;
      wb_waddr_q <= '0;
      wb_wena_q  <= 1'b0;
      wb_mux_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      wb_alu_q   <= wb_alu_d;
      wb_mem_q   <= wb_mem_d;
      wb_pc4_q   <= wb_pc4_d;
      wb_rs_q    <= wb_rs_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wena_q  <= wb_wena_d;
      wb_mux_q   <= wb_mux_d;
    end
  end

  assign bus.stall = ((state_q == StWait) && (cnt_q != 3'd0)) ||
                     ((state_q == StIdle) && bus.in_valid && (bus.mem_rd || bus.mem_wr) &&
                      HasWait);

  assign bus.misalign      = misalign_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_alu_out    = wb_alu_q;
  assign bus.wb_mem_data   = wb_mem_q;
  assign bus.wb_pc4        = wb_pc4_q;
  assign bus.wb_rs_data    = wb_rs_q;
  assign bus.wb_rf_waddr   = wb_waddr_q;
  assign bus.wb_rf_wena    = wb_wena_q;
  assign bus.wb_rf_mux_sel = wb_mux_q;

endmodule

// File: tb/tb_pipe_mem_ext.sv
// Directed bench for pipe_mem_ext: one instance with zero wait cycles
// (DEPTH 1024) and one with two wait cycles (DEPTH 64).
module tb_pipe_mem_ext;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        iv0 = 1'b0, iv2 = 1'b0;
  logic [31:0] s_alu = '0, s_pc4 = '0, s_rs = '0, s_rt = '0;
  logic [4:0]  s_waddr = '0;
  logic        s_wena = 1'b0, s_rd = 1'b0, s_wr = 1'b0, s_sext = 1'b0;
  logic [2:0]  s_mux = '0;
  logic [1:0]  s_size = '0;

  pipe_mem_ext_if bus0 ();
  pipe_mem_ext_if bus2 ();

  assign bus0.in_valid = iv0;
  assign bus2.in_valid = iv2;
  assign bus0.alu_out = s_alu;      assign bus2.alu_out = s_alu;
  assign bus0.pc4 = s_pc4;          assign bus2.pc4 = s_pc4;
  assign bus0.rs_data = s_rs;       assign bus2.rs_data = s_rs;
  assign bus0.rt_data = s_rt;       assign bus2.rt_data = s_rt;
  assign bus0.rf_waddr = s_waddr;   assign bus2.rf_waddr = s_waddr;
  assign bus0.rf_wena = s_wena;     assign bus2.rf_wena = s_wena;
  assign bus0.rf_mux_sel = s_mux;   assign bus2.rf_mux_sel = s_mux;
  assign bus0.mem_rd = s_rd;        assign bus2.mem_rd = s_rd;
  assign bus0.mem_wr = s_wr;        assign bus2.mem_wr = s_wr;
  assign bus0.size = s_size;        assign bus2.size = s_size;
  assign bus0.sign_ext = s_sext;    assign bus2.sign_ext = s_sext;

  pipe_mem_ext #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pipe_mem_ext #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit d2, input bit v, input bit rd, input bit wr,
                       input logic [1:0] sz, input bit sx, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] wa, input bit we);
    iv0 = v & ~d2;
    iv2 = v & d2;
    s_rd = rd; s_wr = wr; s_size = sz; s_sext = sx;
    s_alu = a; s_rt = d; s_waddr = wa; s_wena = we;
  endtask

  // Zero-wait op: stall must stay low, result lands at the next edge.
  task automatic op0(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                     input logic [31:0] a, input logic [31:0] d, input bit we);
    drive(1'b0, 1'b1, rd, wr, sz, sx, a, d, 5'd4, we);
    #1;
    check_eq("stall0", 32'(bus0.stall), 32'd0);
    tick();
    check_eq("wb_valid0", 32'(bus0.wb_valid), 32'd1);
  endtask

  // Two-wait op accepted in cycle T: stall in T,T+1; wb_valid in T+3.
  task automatic op2(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                     input bit sx, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_data, input bit exp_mis);
    drive(1'b1, 1'b1, rd, wr, sz, sx, a, d, 5'd9, 1'b1);
    #1;
    check_eq({tag, "_stall_T"}, 32'(bus2.stall), 32'd1);
    tick();
    check_eq({tag, "_stall_T1"}, 32'(bus2.stall), 32'd1);
    check_eq({tag, "_valid_T1"}, 32'(bus2.wb_valid), 32'd0);
    tick();
    check_eq({tag, "_stall_T2"}, 32'(bus2.stall), 32'd0);
    check_eq({tag, "_valid_T2"}, 32'(bus2.wb_valid), 32'd0);
    tick();
    check_eq({tag, "_valid_T3"}, 32'(bus2.wb_valid), 32'd1);
    check_eq({tag, "_misalign"}, 32'(bus2.misalign), 32'(exp_mis));
    check_eq({tag, "_wena"}, 32'(bus2.wb_rf_wena), 32'(!exp_mis));
    if (!exp_mis) check_eq({tag, "_data"}, bus2.wb_mem_data, exp_data);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_valid0", 32'(bus0.wb_valid), 32'd0);
    check_eq("rst_alu0", bus0.wb_alu_out, 32'd0);
    check_eq("rst_mem0", bus0.wb_mem_data, 32'd0);
    check_eq("rst_mis0", 32'(bus0.misalign), 32'd0);
    check_eq("rst_stall0", 32'(bus0.stall), 32'd0);
    check_eq("rst_valid2", 32'(bus2.wb_valid), 32'd0);
    check_eq("rst_stall2", 32'(bus2.stall), 32'd0);
    rst = 1'b0;

    // ALU op passthrough
    s_pc4 = 32'h0000_0104; s_rs = 32'hAAAA_5555; s_mux = 3'd5;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0000_0077, 5'd3, 1'b1);
    #1;
    check_eq("alu_stall", 32'(bus0.stall), 32'd0);
    tick();
    check_eq("alu_valid", 32'(bus0.wb_valid), 32'd1);
    check_eq("alu_out", bus0.wb_alu_out, 32'h0000_1234);
    check_eq("alu_pc4", bus0.wb_pc4, 32'h0000_0104);
    check_eq("alu_rs", bus0.wb_rs_data, 32'hAAAA_5555);
    check_eq("alu_memdata", bus0.wb_mem_data, 32'h0000_0077);
    check_eq("alu_waddr", 32'(bus0.wb_rf_waddr), 32'd3);
    check_eq("alu_wena", 32'(bus0.wb_rf_wena), 32'd1);
    check_eq("alu_mux", 32'(bus0.wb_rf_mux_sel), 32'd5);
    check_eq("alu_mis", 32'(bus0.misalign), 32'd0);

    // Word store/load, then sub-word lanes
    op0(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    op0(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    check_eq("lw_10", bus0.wb_mem_data, 32'hDEAD_BEEF);
    op0(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5680, 1'b0);
    op0(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1);
    check_eq("lb_13", bus0.wb_mem_data, 32'hFFFF_FF80);
    op0(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1);
    check_eq("lbu_13", bus0.wb_mem_data, 32'h0000_0080);
    op0(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    check_eq("lw_10_after_sb", bus0.wb_mem_data, 32'h80AD_BEEF);
    op0(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1);
    check_eq("lh_12", bus0.wb_mem_data, 32'hFFFF_80AD);
    op0(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b1);
    check_eq("lhu_10", bus0.wb_mem_data, 32'h0000_BEEF);
    op0(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1);
    check_eq("lbu_11", bus0.wb_mem_data, 32'h0000_00BE);

    // Half stores, one misaligned
    op0(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 1'b0);
    op0(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_CAFE, 1'b0);
    op0(1'b0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_BEEF, 1'b1);
    check_eq("sh_21_mis", 32'(bus0.misalign), 32'd1);
    check_eq("sh_21_wena", 32'(bus0.wb_rf_wena), 32'd0);
    op0(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);
    check_eq("lw_20", bus0.wb_mem_data, 32'hCAFE_3344);
    check_eq("lw_20_mis", 32'(bus0.misalign), 32'd0);

    // Address wrap modulo DEPTH*4
    op0(1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h5A5A_A5A5, 1'b0);
    op0(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    check_eq("lw_wrap0", bus0.wb_mem_data, 32'h5A5A_A5A5);

    // Both rd and wr: the store wins
    op0(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BAD_F00D, 1'b0);
    op0(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1);
    check_eq("lw_30", bus0.wb_mem_data, 32'h0BAD_F00D);

    // Bubble
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    check_eq("bubble_valid", 32'(bus0.wb_valid), 32'd0);

    // Reset mid-traffic
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd4, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst2_valid", 32'(bus0.wb_valid), 32'd0);
    check_eq("rst2_mem", bus0.wb_mem_data, 32'd0);
    check_eq("rst2_alu", bus0.wb_alu_out, 32'd0);
    check_eq("rst2_wena", 32'(bus0.wb_rf_wena), 32'd0);
    iv0 = 1'b0;
    rst = 1'b0;
    tick();

    // WAIT_CYCLES=2 instance
    op2("sw8", 1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0102_0304, 32'h0102_0304, 1'b0);
    op2("lw8", 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0102_0304, 1'b0);
    // ALU op right after: one-cycle latency, no stall
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h66, 5'd7, 1'b1);
    #1;
    check_eq("alu2_stall", 32'(bus2.stall), 32'd0);
    tick();
    check_eq("alu2_valid", 32'(bus2.wb_valid), 32'd1);
    check_eq("alu2_out", bus2.wb_alu_out, 32'h55);
    check_eq("alu2_memdata", bus2.wb_mem_data, 32'h66);

    op2("sw_wrap", 1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 1'b0);
    op2("lw4", 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hA1B2_C3D4, 1'b0);
    op2("lw6_mis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);

    // Abort a store with reset while in WAIT
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'hFFFF_0000, 5'd9, 1'b1);
    tick();
    check_eq("abort_stall", 32'(bus2.stall), 32'd1);
    rst = 1'b1;
    iv2 = 1'b0;
    tick();
    tick();
    check_eq("abort_valid", 32'(bus2.wb_valid), 32'd0);
    check_eq("abort_stall_rst", 32'(bus2.stall), 32'd0);
    check_eq("abort_alu", bus2.wb_alu_out, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("abort_valid_post", 32'(bus2.wb_valid), 32'd0);
    op2("lw8_after_abort", 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0102_0304, 1'b0);
    iv2 = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
